// File: rtl/serial_full_adder.sv
// Bit-serial adder: {cout,sum} = din_a + din_b + cin, one bit per clock, LSB first.
// Optional simulation-only self-check: define SERIAL_FULL_ADDER_CHECK_EN.
module serial_full_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] din_a,
  input  logic [WIDTH-1:0] din_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             bit_s, bit_c;
  logic             accept;
  logic             shifting;
  logic [WIDTH-1:0] r_next;

  assign bit_s    = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
  assign bit_c    = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
  assign accept   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign shifting = (state_q == ST_SHIFT);

  // The result shifter drops its LSB every step, so only WIDTH-1 bits need storage.
  generate
    if (WIDTH == 1) begin : g_r_single
      assign r_next = bit_s;
    end else begin : g_r_multi
      logic [WIDTH-2:0] r_sh_q;
      assign r_next = {bit_s, r_sh_q};
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_sh_q <= '0;
        else if (shifting) r_sh_q <= r_next[WIDTH-1:1];
      end
    end
  endgenerate

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept) begin
          a_sh_d  = din_a;
          b_sh_d  = din_b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = bit_c;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          sum_d   = r_next;
          cout_d  = bit_c;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: datapath registers are reset too, so an aborted operation leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == ST_SHIFT);
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

`ifdef SERIAL_FULL_ADDER_CHECK_EN
  logic [WIDTH-1:0] opa_q, opb_q;
  logic             opc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_q <= '0;
      opb_q <= '0;
      opc_q <= 1'b0;
    end else if (accept) begin
      opa_q <= din_a;
      opb_q <= din_b;
      opc_q <= cin;
    end
  end

  always_comb begin
    if (rst_n && (state_q == ST_DONE)) begin
      assert ({cout_q, sum_q} == ({1'b0, opa_q} + {1'b0, opb_q} + {{WIDTH{1'b0}}, opc_q}))
        else $error("serial_full_adder: a=%0h b=%0h cin=%0b gave cout=%0b sum=%0h",
                    opa_q, opb_q, opc_q, cout_q, sum_q);
    end
    assert (!(busy && done)) else $error("serial_full_adder: busy and done both high");
  end
`endif

endmodule

// File: tb/tb_serial_full_adder.sv
// Directed bench for serial_full_adder: arithmetic model plus literal expectations.
module tb_serial_full_adder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] din_a, din_b;
  logic         cin;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         cout;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  serial_full_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .din_a(din_a), .din_b(din_b),
    .cin(cin), .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted start books the arithmetic result, due W cycles later.
  int         m_rem = 0;
  bit         m_done = 1'b0;
  logic [W:0] m_pend = '0;
  logic [W:0] m_res = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem  = 0;
      m_done = 1'b0;
      m_res  = '0;
    end else if (m_rem > 0) begin
      m_rem--;
      m_done = (m_rem == 0);
      if (m_rem == 0) m_res = m_pend;
    end else begin
      m_done = 1'b0;
      if (start) begin
        m_pend = {1'b0, din_a} + {1'b0, din_b} + {{W{1'b0}}, cin};
        m_rem  = W;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      check("model_busy", busy, (m_rem > 0));
      check("model_done", done, m_done);
      check("model_sum", sum, m_res[W-1:0]);
      check("model_cout", cout, m_res[W]);
    end
  end

  function automatic logic [W:0] full_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] d;
    logic         br;
    br = 1'b0;
    for (int i = 0; i < W; i++) begin
      d[i] = a[i] ^ b[i] ^ br;
      br   = (~a[i] & b[i]) | (~a[i] & br) | (b[i] & br);
    end
    return {br, d};
  endfunction

  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 4 * W + 4; i++) begin
      @(negedge clk);
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        output int lat);
    @(negedge clk);
    start = 1'b1; din_a = a; din_b = b; cin = c;
    lat = 0;
    for (int i = 1; i <= 4 * W + 4; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start = 1'b0; din_a = W'($urandom); din_b = W'($urandom); cin = 1'($urandom);
      end
      if (done) begin
        lat = i;
        break;
      end
    end
    check("latency", lat, W + 1);
  endtask

  initial begin
    int lat, first, second;
    logic [W:0]   sub;
    logic [W-1:0] ra, rb;

    rst_n = 1'b0; start = 1'b0; din_a = '0; din_b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // Basic add
    run_op(8'h3C, 8'h15, 1'b0, lat);
    check("t1_sum", sum, 8'h51);
    check("t1_cout", cout, 0);

    // Carry out and all-ones
    run_op(8'hFF, 8'h01, 1'b0, lat);
    check("t2a_sum", sum, 8'h00);
    check("t2a_cout", cout, 1);
    run_op(8'hFF, 8'hFF, 1'b1, lat);
    check("t2b_sum", sum, 8'hFF);
    check("t2b_cout", cout, 1);

    // Start during SHIFT is ignored; prior result held
    @(negedge clk);
    start = 1'b1; din_a = 8'h10; din_b = 8'h20; cin = 1'b0;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); start = 1'b1; din_a = 8'hAA;
    @(negedge clk); start = 1'b0;
    check("t3_hold_sum", sum, 8'hFF);
    check("t3_hold_cout", cout, 1);
    wait_done(lat);
    check("t3_latency", lat, 5);
    check("t3_sum", sum, 8'h30);
    check("t3_cout", cout, 0);
    @(negedge clk);
    check("t3_no_requeue", busy, 0);

    // Asynchronous reset mid-operation
    @(negedge clk);
    start = 1'b1; din_a = 8'h77; din_b = 8'h11; cin = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("t4_rst_busy", busy, 0);
    check("t4_rst_done", done, 0);
    check("t4_rst_sum", sum, 0);
    check("t4_rst_cout", cout, 0);
    @(negedge clk); rst_n = 1'b1;
    run_op(8'h01, 8'h01, 1'b1, lat);
    check("t4_sum", sum, 8'h03);
    check("t4_cout", cout, 0);

    // Round trip through a bit-wise full subtractor
    for (int k = 0; k < 8; k++) begin
      ra  = W'($urandom);
      rb  = W'($urandom);
      sub = full_sub(ra, rb);
      run_op(sub[W-1:0], rb, 1'b0, lat);
      check("t5_restore", sum, ra);
      check("t5_borrow", cout, sub[W]);
    end

    // Back-to-back with start held high
    @(negedge clk);
    start = 1'b1; din_a = 8'h5A; din_b = 8'h33; cin = 1'b1;
    first = -1; second = -1;
    for (int c = 1; c <= 5 * W && second < 0; c++) begin
      @(negedge clk);
      if (done) begin
        if (first < 0) first = c;
        else second = c;
      end
      if (second < 0) begin
        din_a = W'($urandom); din_b = W'($urandom); cin = 1'($urandom);
      end
    end
    start = 1'b0;
    check("t6_first", first, W + 1);
    check("t6_spacing", second - first, W + 1);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
